wb_regfile: RTL and testbench

Write-back stage and general-purpose register file of the five-stage pipeline. Consumes the MEM/WB pipeline register outputs, decodes the retiring instruction, selects and formats the write-back value, and commits it to a 32×32-bit register file. Provides two combinational read ports with same-cycle write bypass to the decode stage, and a write-back status bus for forwarding.

---
 rtl/wb_regfile_if.sv | 26 ++
 rtl/wb_regfile.sv | 126 ++++++++++++
 tb/tb_wb_regfile.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus: retiring instruction in, register read ports and
// write-back status out.
interface wb_regfile_if;
  logic [31:0] ins_W;
  logic [31:0] pc_W;
  logic [31:0] alu_Result_W;
  logic [31:0] DMRData_W;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retired;

  modport master (
    output ins_W, pc_W, alu_Result_W, DMRData_W, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_we, wb_addr, wb_data, retired
  );

  modport slave (
    input  ins_W, pc_W, alu_Result_W, DMRData_W, rs_addr, rt_addr,
    output rs_data, rt_data, wb_we, wb_addr, wb_data, retired
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: decodes the retiring instruction, formats the result and
// commits it to a 32x32 register file with bypassed combinational read ports.
module wb_regfile (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] retired_q;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] link;

  logic          wr_c;
  logic [AW-1:0] dest_c;
  logic [DW-1:0] val_c;
  logic          we_c;

  assign op    = bus.ins_W[31:26];
  assign rt    = bus.ins_W[20:16];
  assign rd    = bus.ins_W[15:11];
  assign funct = bus.ins_W[5:0];
  assign link  = bus.pc_W + 32'd8;

  // Little-endian lane selection for sub-word loads
  always_comb begin
    ld_byte = bus.DMRData_W[7:0];
    case (bus.alu_Result_W[1:0])
      2'd0: ld_byte = bus.DMRData_W[7:0];
      2'd1: ld_byte = bus.DMRData_W[15:8];
      2'd2: ld_byte = bus.DMRData_W[23:16];
      2'd3: ld_byte = bus.DMRData_W[31:24];
      default: ld_byte = bus.DMRData_W[7:0];
    endcase
    ld_half = bus.alu_Result_W[1] ? bus.DMRData_W[31:16] : bus.DMRData_W[15:0];
  end

  // Destination and write-back value decode
  always_comb begin
    wr_c   = 1'b0;
    dest_c = '0;
    val_c  = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            wr_c = 1'b1; dest_c = rd; val_c = bus.alu_Result_W;
          end
          6'h09: begin
            wr_c = 1'b1; dest_c = rd; val_c = link;
          end
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        wr_c = 1'b1; dest_c = rt; val_c = bus.alu_Result_W;
      end
      6'h03: begin
        wr_c = 1'b1; dest_c = AW'(31); val_c = link;
      end
      6'h23: begin
        wr_c = 1'b1; dest_c = rt; val_c = bus.DMRData_W;
      end
      6'h20: begin
        wr_c = 1'b1; dest_c = rt; val_c = {{24{ld_byte[7]}}, ld_byte};
      end
      6'h24: begin
        wr_c = 1'b1; dest_c = rt; val_c = {24'd0, ld_byte};
      end
      6'h21: begin
        wr_c = 1'b1; dest_c = rt; val_c = {{16{ld_half[15]}}, ld_half};
      end
      6'h25: begin
        wr_c = 1'b1; dest_c = rt; val_c = {16'd0, ld_half};
      end
      default: ;
    endcase
  end

  assign we_c        = wr_c && (dest_c != '0);
  assign bus.wb_we   = we_c;
  assign bus.wb_addr = we_c ? dest_c : '0;
  assign bus.wb_data = we_c ? val_c : '0;
  assign bus.retired = retired_q;

  // Read ports with same-cycle write bypass; r0 hardwired to zero
  always_comb begin
    bus.rs_data = regs[bus.rs_addr];
    if (bus.rs_addr == '0)
      bus.rs_data = '0;
    else if (we_c && bus.rs_addr == dest_c)
      bus.rs_data = val_c;
  end

  always_comb begin
    bus.rt_data = regs[bus.rt_addr];
    if (bus.rt_addr == '0)
      bus.rt_data = '0;
    else if (we_c && bus.rt_addr == dest_c)
      bus.rt_data = val_c;
  end

  // Commit and retire counter; reset drops any write presented that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[AW'(i)] <= '0;
      retired_q <= '0;
    end else begin
      if (we_c)
        regs[dest_c] <= val_c;
      if (bus.ins_W != '0)
        retired_q <= retired_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based
// reference model of the write-back rules.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if bus ();
  wb_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_ret;

  logic [31:0] obs_rs, obs_rt, obs_wd, obs_ret;
  logic [4:0]  obs_wa;
  logic        obs_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Architectural effect of a retiring instruction
  function automatic void ref_wb(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] dmr,
                                 output logic we, output logic [4:0] wa,
                                 output logic [31:0] wd);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [7:0]  b;
    logic [15:0] h;
    logic        w;
    logic [4:0]  d;
    logic [31:0] v;
    op = ins[31:26];
    fn = ins[5:0];
    b  = 8'(dmr >> (8 * alu[1:0]));
    h  = 16'(dmr >> (16 * alu[1]));
    w  = 1'b0; d = 5'd0; v = 32'd0;
    if (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                                  6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}) begin
      w = 1'b1; d = ins[15:11]; v = alu;
    end else if (op == 6'h00 && fn == 6'h09) begin
      w = 1'b1; d = ins[15:11]; v = pc + 32'd8;
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      w = 1'b1; d = ins[20:16]; v = alu;
    end else if (op == 6'h03) begin
      w = 1'b1; d = 5'd31; v = pc + 32'd8;
    end else if (op == 6'h23) begin
      w = 1'b1; d = ins[20:16]; v = dmr;
    end else if (op == 6'h20 || op == 6'h24) begin
      w = 1'b1; d = ins[20:16];
      v = (op == 6'h20 && b[7]) ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
    end else if (op == 6'h21 || op == 6'h25) begin
      w = 1'b1; d = ins[20:16];
      v = (op == 6'h21 && h[15]) ? (32'hFFFF0000 | 32'(h)) : 32'(h);
    end
    we = w && (d != 5'd0);
    wa = we ? d : 5'd0;
    wd = we ? v : 32'd0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && a == wa) return wd;
    return model_regs[a];
  endfunction

  // One cycle: drive at negedge, check mid-cycle, update model at the edge
  task automatic apply(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] dmr,
                       input logic [4:0] ra, input logic [4:0] rb);
    logic        we_e;
    logic [4:0]  wa_e;
    logic [31:0] wd_e;
    @(negedge clk);
    rst = r;
    bus.ins_W = ins; bus.pc_W = pc; bus.alu_Result_W = alu; bus.DMRData_W = dmr;
    bus.rs_addr = ra; bus.rt_addr = rb;
    #1;
    ref_wb(ins, pc, alu, dmr, we_e, wa_e, wd_e);
    check("wb_we",   32'(bus.wb_we),   32'(we_e));
    check("wb_addr", 32'(bus.wb_addr), 32'(wa_e));
    check("wb_data", bus.wb_data, wd_e);
    check("rs_data", bus.rs_data, ref_read(ra, we_e, wa_e, wd_e));
    check("rt_data", bus.rt_data, ref_read(rb, we_e, wa_e, wd_e));
    check("retired", bus.retired, model_ret);
    obs_rs = bus.rs_data; obs_rt = bus.rt_data; obs_we = bus.wb_we;
    obs_wa = bus.wb_addr; obs_wd = bus.wb_data; obs_ret = bus.retired;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_ret = 32'd0;
    end else begin
      if (we_e) model_regs[wa_e] = wd_e;
      if (ins != 32'd0) model_ret = model_ret + 32'd1;
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0]  fl [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24,
                              6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h09, 6'h08, 6'h18, 6'h1A};
    logic [5:0]  ol [20] = '{6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h04, 6'h05,
                              6'h02, 6'h3F, 6'h28};
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 29);
    if (k < 3)       w = 32'd0;
    else if (k < 12) begin w[31:26] = 6'h00; w[5:0] = fl[$urandom_range(0, 17)]; end
    else             w[31:26] = ol[$urandom_range(0, 19)];
    return w;
  endfunction

  localparam logic [31:0] DMR = 32'h80F17F02;
  localparam logic [31:0] PC  = 32'h00400010;

  initial begin
    logic [31:0] ins;
    logic [4:0]  ra, rb;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_ret = 32'd0;
    bus.ins_W = '0; bus.pc_W = '0; bus.alu_Result_W = '0; bus.DMRData_W = '0;
    bus.rs_addr = '0; bus.rt_addr = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);

    // Reset clears a preloaded register and the counter
    apply(1'b0, {6'h09, 5'd0, 5'd5, 16'h1234}, PC, 32'h1234, 0, 5'd5, 5'd0);
    apply(1'b0, 32'd0, PC, 0, 0, 5'd5, 5'd0);
    check("preload_r5", obs_rs, 32'h1234);
    apply(1'b1, 32'd0, PC, 0, 0, 5'd5, 5'd0);
    apply(1'b0, 32'd0, PC, 0, 0, 5'd5, 5'd0);
    check("rst_r5", obs_rs, 32'd0);
    check("rst_ret", obs_ret, 32'd0);

    // ALU write with bypass, then stored value
    apply(1'b0, 32'h00000021 | (32'd8 << 11), PC, 32'hDEADBEEF, 0, 5'd8, 5'd0);
    check("addu_byp", obs_rs, 32'hDEADBEEF);
    check("addu_we", 32'(obs_we), 32'd1);
    check("addu_wa", 32'(obs_wa), 32'd8);
    apply(1'b0, 32'd0, PC, 0, 0, 5'd8, 5'd0);
    check("addu_st", obs_rs, 32'hDEADBEEF);

    // Loads on every lane/half
    apply(1'b0, {6'h20, 5'd0, 5'd3, 16'd0}, PC, 32'h00001001, DMR, 5'd3, 5'd0);
    check("lb_l1", obs_rs, 32'h0000007F);
    apply(1'b0, {6'h20, 5'd0, 5'd3, 16'd0}, PC, 32'h00001003, DMR, 5'd3, 5'd0);
    check("lb_l3", obs_rs, 32'hFFFFFF80);
    apply(1'b0, {6'h24, 5'd0, 5'd3, 16'd0}, PC, 32'h00001003, DMR, 5'd3, 5'd0);
    check("lbu_l3", obs_rs, 32'h00000080);
    apply(1'b0, {6'h21, 5'd0, 5'd3, 16'd0}, PC, 32'h00001003, DMR, 5'd3, 5'd0);
    check("lh_hi", obs_rs, 32'hFFFF80F1);
    apply(1'b0, {6'h25, 5'd0, 5'd3, 16'd0}, PC, 32'h00001002, DMR, 5'd0, 5'd3);
    check("lhu_hi", obs_rt, 32'h000080F1);

    // Links
    apply(1'b0, {6'h03, 26'h0100004}, PC, 0, 0, 5'd31, 5'd0);
    check("jal", obs_rs, 32'h00400018);
    apply(1'b0, {6'h00, 5'd4, 5'd0, 5'd9, 5'd0, 6'h09}, PC, 0, 0, 5'd9, 5'd31);
    check("jalr", obs_rs, 32'h00400018);
    check("jal_st", obs_rt, 32'h00400018);

    // $0 and non-writing instructions
    apply(1'b0, {6'h09, 5'd0, 5'd0, 16'h0005}, PC, 32'd5, 0, 5'd0, 5'd0);
    check("r0_we", 32'(obs_we), 32'd0);
    check("r0_rd", obs_rs, 32'd0);
    apply(1'b0, {6'h2B, 5'd1, 5'd8, 16'h0010}, PC, 32'h10, 0, 5'd8, 5'd3);
    check("sw_we", 32'(obs_we), 32'd0);
    apply(1'b0, {6'h04, 5'd8, 5'd3, 16'h0004}, PC, 0, 0, 5'd8, 5'd3);
    check("beq_we", 32'(obs_we), 32'd0);

    // Counter: 3 instructions then 2 bubbles
    apply(1'b1, 32'd0, PC, 0, 0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      apply(1'b0, {6'h09, 5'd0, 5'd1, 16'h0001}, PC, 32'd1, 0, 5'd1, 5'd0);
    apply(1'b0, 32'd0, PC, 0, 0, 5'd1, 5'd0);
    apply(1'b0, 32'd0, PC, 0, 0, 5'd1, 5'd0);
    check("ret_3", obs_ret, 32'd3);

    // Counter wrap
    @(negedge clk);
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    model_ret = 32'hFFFFFFFF;
    apply(1'b0, {6'h09, 5'd0, 5'd2, 16'h0002}, PC, 32'd2, 0, 5'd2, 5'd0);
    apply(1'b0, 32'd0, PC, 0, 0, 5'd2, 5'd0);
    check("ret_wrap", obs_ret, 32'd0);

    // Randomized traffic, reads biased toward the destination fields
    for (int n = 0; n < 600; n++) begin
      ins = rand_ins();
      ra = ($urandom_range(0, 1) == 0) ? ins[20:16] : 5'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? ins[15:11] : 5'($urandom);
      apply(($urandom_range(0, 79) == 0), ins, $urandom, $urandom, $urandom, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
